// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared pool opcodes, default widths and str_pack state encoding
package pool_pkg;

    localparam int ASZ_DEF = 16;
    localparam int DSZ_DEF = 32;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_W4  = 3'd1,
        OP_R4  = 3'd2,
        OP_W1  = 3'd3,
        OP_R1  = 3'd4
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PACK,
        ST_FLUSH,
        ST_PATCH,
        ST_DONE
    } str_pack_st_t;

endpackage

// File: rtl/byte_lane_pack.sv
// rtl/byte_lane_pack.sv - little-endian byte-to-word merge register with lane count
module byte_lane_pack #(
    parameter int DSZ = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           skip0,
    input  logic           push,
    input  logic [7:0]     din,
    output logic [DSZ-1:0] merged,
    output logic [DSZ-1:0] padded,
    output logic           full,
    output logic           empty
);
    localparam int NB = DSZ / 8;
    localparam int CW = $clog2(NB);

    logic [DSZ-1:0] data;
    logic [CW-1:0]  cnt;

    assign full   = (cnt == CW'(NB - 1));
    assign empty  = (cnt == '0);
    // unfilled upper lanes are always zero, so the held data doubles as the padded word
    assign padded = data;

    always_comb begin
        merged = data;
        merged[{cnt, 3'b000} +: 8] = din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
            cnt  <= '0;
        end else if (clr) begin
            data <= '0;
            cnt  <= skip0 ? CW'(1) : '0;
        end else if (push) begin
            if (full) begin
                data <= '0;
                cnt  <= '0;
            end else begin
                data <= merged;
                cnt  <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/str_pack.sv
// rtl/str_pack.sv - packs a byte string into 32-bit pool writes; STR_PACK_COUNTED_EN adds a length-prefix byte
module str_pack
    import pool_pkg::*;
#(
    parameter int ASZ = ASZ_DEF,
    parameter int DSZ = DSZ_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [ASZ-1:0] base,
    input  logic           in_vld,
    input  logic [7:0]     in_byte,
    input  logic           in_last,
    output logic           in_rdy,
    output op_t            op,
    output logic [ASZ-1:0] ai,
    output logic [DSZ-1:0] vi,
    output logic           busy,
    output logic           done,
    output logic [7:0]     len,
    output logic           ovf
);
`ifdef STR_PACK_COUNTED_EN
    localparam logic         SKIP0  = 1'b1;
    localparam str_pack_st_t ST_END = ST_PATCH;
    logic [DSZ-1:8] held;
`else
    localparam logic         SKIP0  = 1'b0;
    localparam str_pack_st_t ST_END = ST_DONE;
`endif

    str_pack_st_t   st;
    logic [ASZ-1:0] base_q;
    logic [ASZ-1:0] widx;
    logic [DSZ-1:0] merged;
    logic [DSZ-1:0] padded;
    logic           full;
    logic           empty;
    logic           accept;
    logic           keep;
    logic           partial;
    logic           clr;

    assign accept  = (st == ST_PACK) && in_vld && in_rdy;
    assign keep    = accept && (len != 8'hFF);
    assign partial = keep ? !full : !empty;
    assign clr     = (st == ST_IDLE) && start;

    byte_lane_pack #(.DSZ(DSZ)) u_lane (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .skip0  (SKIP0),
        .push   (keep),
        .din    (in_byte),
        .merged (merged),
        .padded (padded),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= ST_IDLE;
            op     <= OP_NOP;
            ai     <= '0;
            vi     <= '0;
            in_rdy <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            len    <= '0;
            ovf    <= 1'b0;
            base_q <= '0;
            widx   <= '0;
`ifdef STR_PACK_COUNTED_EN
            held   <= '0;
`endif
        end else begin
            op   <= OP_NOP;
            done <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (start) begin
                        base_q <= base;
                        widx   <= '0;
                        len    <= '0;
                        ovf    <= 1'b0;
                        in_rdy <= 1'b1;
                        busy   <= 1'b1;
                        st     <= ST_PACK;
                    end
                end
                ST_PACK: begin
                    if (accept) begin
                        if (keep) begin
                            len <= len + 8'd1;
                        end else begin
                            ovf <= 1'b1;
                        end
                        if (keep && full) begin
                            op   <= OP_W4;
                            ai   <= base_q + widx;
                            vi   <= merged;
                            widx <= widx + ASZ'(1);
`ifdef STR_PACK_COUNTED_EN
                            if (widx == '0) held <= merged[DSZ-1:8];
`endif
                        end
                        if (in_last) begin
                            in_rdy <= 1'b0;
                            st     <= partial ? ST_FLUSH : ST_END;
                        end
                    end
                end
                ST_FLUSH: begin
                    op <= OP_W4;
                    ai <= base_q + widx;
                    vi <= padded;
`ifdef STR_PACK_COUNTED_EN
                    if (widx == '0) held <= padded[DSZ-1:8];
`endif
                    st <= ST_END;
                end
                ST_PATCH: begin
`ifdef STR_PACK_COUNTED_EN
                    // rewrite the first word so its reserved byte carries the final length
                    op <= OP_W4;
                    ai <= base_q;
                    vi <= {held, len};
`endif
                    st <= ST_DONE;
                end
                ST_DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    st   <= ST_IDLE;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_str_pack.sv
// tb/tb_str_pack.sv - randomized self-checking bench for str_pack against a byte-stream model
module tb_str_pack;
    import pool_pkg::*;

    localparam int ASZ = 16;
    localparam int DSZ = 32;
`ifdef STR_PACK_COUNTED_EN
    localparam int SKIP = 1;
`else
    localparam int SKIP = 0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [ASZ-1:0] base = '0;
    logic           in_vld = 1'b0;
    logic [7:0]     in_byte = '0;
    logic           in_last = 1'b0;
    logic           in_rdy;
    op_t            op;
    logic [ASZ-1:0] ai;
    logic [DSZ-1:0] vi;
    logic           busy;
    logic           done;
    logic [7:0]     len;
    logic           ovf;

    str_pack #(.ASZ(ASZ), .DSZ(DSZ)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .base    (base),
        .in_vld  (in_vld),
        .in_byte (in_byte),
        .in_last (in_last),
        .in_rdy  (in_rdy),
        .op      (op),
        .ai      (ai),
        .vi      (vi),
        .busy    (busy),
        .done    (done),
        .len     (len),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [ASZ-1:0] wa_q[$];
    logic [DSZ-1:0] wd_q[$];
    int             done_cnt = 0;
    logic [7:0]     len_at_done;
    logic           ovf_at_done;

    always @(negedge clk) begin
        if (!rst) begin
            if (op != OP_NOP) begin
                chk("op_legal", 64'(op), 64'(OP_W4));
                wa_q.push_back(ai);
                wd_q.push_back(vi);
            end
            if (done) begin
                done_cnt++;
                len_at_done = len;
                ovf_at_done = ovf;
            end
        end
    end

    logic [7:0]     pay[$];
    logic [ASZ-1:0] ea_q[$];
    logic [DSZ-1:0] ed_q[$];
    logic [7:0]     exp_len;
    logic           exp_ovf;

    task automatic model(input logic [ASZ-1:0] b);
        logic [7:0]     stream[$];
        int             kept;
        int             nw;
        logic [DSZ-1:0] w;
        logic [ASZ-1:0] a;
        ea_q.delete();
        ed_q.delete();
        kept = (pay.size() > 255) ? 255 : pay.size();
        if (SKIP == 1) stream.push_back(8'h00);
        for (int i = 0; i < kept; i++) stream.push_back(pay[i]);
        nw = (stream.size() + 3) / 4;
        for (int k = 0; k < nw; k++) begin
            w = '0;
            for (int j = 0; j < 4; j++)
                if (4 * k + j < stream.size()) w[8*j +: 8] = stream[4*k+j];
            a = b + ASZ'(k);
            ea_q.push_back(a);
            ed_q.push_back(w);
        end
        exp_len = 8'(kept);
        exp_ovf = (pay.size() > 255);
        if (SKIP == 1) begin
            w = ed_q[0];
            w[7:0] = exp_len;
            ea_q.push_back(b);
            ed_q.push_back(w);
        end
    endtask

    task automatic begin_string(input logic [ASZ-1:0] b);
        wa_q.delete();
        wd_q.delete();
        done_cnt = 0;
        @(negedge clk);
        start   = 1'b1;
        base    = b;
        in_vld  = 1'($urandom_range(0, 1));
        in_byte = 8'hEE;
        in_last = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        in_vld  = 1'b0;
        in_last = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic send_bytes(input int upto, input bit gaps, input bit mid_start, output int stalls);
        logic rdy;
        int   tries;
        stalls = 0;
        for (int i = 0; i < upto; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_vld = 1'b0;
                @(negedge clk);
            end
            in_vld  = 1'b1;
            in_byte = pay[i];
            in_last = (i == pay.size() - 1);
            if (mid_start && i == 5) begin
                start = 1'b1;
                base  = 16'h0080;
            end
            tries = 0;
            forever begin
                rdy = in_rdy;
                @(negedge clk);
                start = 1'b0;
                if (rdy) break;
                stalls++;
                tries++;
                if (tries > 20) begin
                    chk("in_rdy_wait", 64'(rdy), 64'd1);
                    break;
                end
            end
        end
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic finish_string(input string tag);
        for (int t = 0; t < 100 && done_cnt == 0; t++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk({tag, "_done_once"}, 64'(done_cnt), 64'd1);
        chk({tag, "_nwrites"}, 64'(wa_q.size()), 64'(ea_q.size()));
        for (int i = 0; i < ea_q.size() && i < wa_q.size(); i++) begin
            chk({tag, "_addr"}, 64'(wa_q[i]), 64'(ea_q[i]));
            chk({tag, "_data"}, 64'(wd_q[i]), 64'(ed_q[i]));
        end
        chk({tag, "_len_at_done"}, 64'(len_at_done), 64'(exp_len));
        chk({tag, "_ovf_at_done"}, 64'(ovf_at_done), 64'(exp_ovf));
        chk({tag, "_len_held"}, 64'(len), 64'(exp_len));
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    endtask

    task automatic run_string(input string tag, input logic [ASZ-1:0] b, input bit gaps,
                              input bit mid_start);
        int stalls;
        model(b);
        begin_string(b);
        send_bytes(pay.size(), gaps, mid_start, stalls);
        finish_string(tag);
    endtask

    task automatic load_text(input string s);
        pay.delete();
        for (int i = 0; i < s.len(); i++) pay.push_back(s[i]);
    endtask

    task automatic load_rand(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    endtask

    initial begin
        int stalls;
        int lens[8] = '{1, 3, 4, 5, 7, 8, 255, 256};

        repeat (3) @(negedge clk);
        chk("rst_op", 64'(op), 64'(OP_NOP));
        chk("rst_ai", 64'(ai), 64'd0);
        chk("rst_vi", 64'(vi), 64'd0);
        chk("rst_in_rdy", 64'(in_rdy), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_len", 64'(len), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        load_text("abcdefghijklmnop");
        run_string("str16", 16'h0000, 1'b0, 1'b0);
        load_text("abcde");
        run_string("str5", 16'h0010, 1'b0, 1'b0);
        load_text("abcd");
        run_string("str4", 16'h0000, 1'b0, 1'b0);

        foreach (lens[i]) begin
            load_rand(lens[i]);
            run_string("edge_len", 16'($urandom), 1'b1, 1'b0);
        end

        for (int k = 0; k < 15; k++) begin
            load_rand($urandom_range(1, 40));
            run_string("rand", 16'($urandom), 1'b1, 1'b0);
        end

        load_rand(16);
        run_string("mid_start", 16'h0020, 1'b1, 1'b1);

        load_rand(16);
        model(16'h0040);
        begin_string(16'h0040);
        send_bytes(6, 1'b0, 1'b0, stalls);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 10; t++) begin
            chk("abort_op", 64'(op), 64'(OP_NOP));
            chk("abort_busy", 64'(busy), 64'd0);
            @(negedge clk);
        end
        chk("abort_nwrites", 64'(wa_q.size()), 64'((6 + SKIP) / 4));
        if (wa_q.size() > 0) begin
            chk("abort_addr", 64'(wa_q[0]), 64'(ea_q[0]));
            chk("abort_data", 64'(wd_q[0]), 64'(ed_q[0]));
        end
        chk("abort_done", 64'(done_cnt), 64'd0);

        load_rand(9);
        run_string("after_abort", 16'h0050, 1'b1, 1'b0);

        load_rand(300);
        model(16'h0100);
        begin_string(16'h0100);
        send_bytes(pay.size(), 1'b0, 1'b0, stalls);
        chk("long_stalls", 64'(stalls), 64'd0);
        finish_string("long300");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
